// File: rtl/rf_pkg.sv
// Purpose: shared register-file types and default sizes for the pipeline stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_clr_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Purpose: walks an index over every register once to zero the file.
// Latency: clr_busy rises one cycle after clr_start and stays high NUM_REGS cycles.
// Backpressure: none; clr_start while busy is ignored.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_clr_state_t state;

  // Clear FSM: IDLE waits for a start, CLEAR zeroes one index per cycle and stops at the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Every CLEAR cycle zeroes the register at the current index.
  assign clr_we = clr_busy;

endmodule

// File: rtl/regfile_mp.sv
// Purpose: multi-read-port integer register file with write bypass, pending scoreboard and clear engine.
// Latency: reads combinational (zero cycles); writes/claims take effect on the next rising edge.
// Backpressure: none; writes and claims are dropped while the clear engine is busy.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  bit ZERO_REG = 1'b1,
  parameter  bit BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  input  logic                     clr_start,
  output logic                     clr_busy
);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_W-1:0]   clr_idx;
  logic                clr_we;
  logic                wr_ok;
  logic                claim_ok;
  logic                clr_go;
  logic                byp_ok;

  rf_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_idx   (clr_idx),
    .clr_we    (clr_we)
  );

  // Register 0 is hardwired when ZERO_REG is set, so writes and claims to it never land.
  assign wr_ok    = we && !clr_busy && !(ZERO_REG && (wr_addr == '0));
  assign claim_ok = claim_en && !(ZERO_REG && (claim_addr == '0));
  assign clr_go   = clr_start && !clr_busy;
  // Bypass is gated by reset so outputs read zero while reset is held.
  assign byp_ok   = BYPASS && wr_ok && reset;

  // Storage: clear engine owns the array while busy, otherwise the write port updates it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard next state: claim wins over flush and write-clear; clear entry/activity wipes all.
  always_comb begin
    pend_nxt = pending;
    if (clr_go || clr_busy) begin
      pend_nxt = '0;
    end else begin
      if (flush) begin
        pend_nxt = '0;
      end
      if (wr_ok) begin
        pend_nxt[wr_addr] = 1'b0;
      end
      if (claim_ok) begin
        pend_nxt[claim_addr] = 1'b1;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pend_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] dat;
    logic              busy;

    assign ra  = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit = byp_ok && (ra == wr_addr);

    // Read mux: zero register first, then same-cycle write forwarding, then storage.
    always_comb begin
      dat  = mem[ra];
      busy = pending[ra];
      if (ZERO_REG && (ra == '0)) begin
        dat  = '0;
        busy = 1'b0;
      end else if (hit) begin
        dat  = wr_data;
        busy = 1'b0;
      end
      if (clr_busy) begin
        busy = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = dat;
    assign rd_busy[g]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose: self-checking bench for regfile_mp with directed scenarios and a randomized reference model.
// Latency: checks combinational reads before each edge, state effects one cycle later.
// Backpressure: n/a.
module tb_regfile_mp;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [AW-1:0]   a0, a1;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]  rd_busy;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            claim_en;
  logic [AW-1:0]   claim_addr;
  logic            flush;
  logic            clr_start;
  logic            clr_busy;

  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays plus a countdown for the clear sweep.
  logic [DW-1:0] m_mem  [NR];
  logic          m_pend [NR];
  int            m_left;
  int            m_pos;

  assign rd_addr = {a1, a0};

  regfile_mp dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (m_left == 0 && we && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (m_left > 0) return 1'b0;
    if (a == 0) return 1'b0;
    if (we && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 1'b0;
    end
    m_left = 0;
    m_pos  = 0;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
    flush = 1'b0; clr_start = 1'b0;
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (m_left > 0) begin
      m_mem[m_pos] = '0;
      m_pos++;
      m_left--;
    end else begin
      if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (flush) for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
      if (we) m_pend[wr_addr] = 1'b0;
      if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
      if (clr_start) begin
        m_left = NR;
        m_pos  = 0;
        for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    a0 = 5'd5; a1 = 5'd17;
    we = 1'b1; wr_addr = 5'd5; wr_data = 64'hFFFF_0000_FFFF_0000;
    #3;
    tests++;
    if (rd_data !== '0 || rd_busy !== '0 || clr_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: rd_data=%h rd_busy=%b clr_busy=%b, want all 0", rd_data, rd_busy, clr_busy);
    end
    we = 1'b0;
    do_reset();
    for (int a = 0; a < NR; a++) begin
      a0 = AW'(a); a1 = AW'(NR - 1 - a);
      #1;
      tests++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        fails++;
        $display("FAIL reset_read r%0d: rd_data=%h rd_busy=%b, want 0", a, rd_data, rd_busy);
      end
    end
    a0 = 5'd0; a1 = 5'd0;
    we = 1'b1; wr_addr = 5'd0; wr_data = 64'hDEAD;
    #1;
    tests++;
    if (rd_data !== '0) begin
      fails++;
      $display("FAIL zero_reg_bypass: rd_data=%h, want 0", rd_data);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (rd_data !== '0 || clr_busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_reg_store: rd_data=%h clr_busy=%b, want 0/0", rd_data, clr_busy);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] v;
    v = 64'h1234_5678_9ABC_DEF0;
    idle_inputs();
    a0 = 5'd6; a1 = 5'd5;
    we = 1'b1; wr_addr = 5'd5; wr_data = v;
    #1;
    tests++;
    if (rd_data[2*DW-1:DW] !== v) begin
      fails++;
      $display("FAIL bypass_same_cycle: got %h want %h", rd_data[2*DW-1:DW], v);
    end
    tick();
    we = 1'b0; wr_data = '0;
    #1;
    tests++;
    if (rd_data[2*DW-1:DW] !== v) begin
      fails++;
      $display("FAIL bypass_next_cycle: got %h want %h", rd_data[2*DW-1:DW], v);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    a0 = 5'd7; a1 = 5'd0;
    claim_en = 1'b1; claim_addr = 5'd7;
    #1;
    tests++;
    if (rd_busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL claim_cycle_busy: got %b want 0", rd_busy[0]);
    end
    tick();
    claim_en = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      tests++;
      if (rd_busy[0] !== 1'b1) begin
        fails++;
        $display("FAIL claim_busy_c%0d: got %b want 1", c, rd_busy[0]);
      end
      tick();
    end
    we = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
    #1;
    tests++;
    if (rd_busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL write_cycle_busy: got %b want 0", rd_busy[0]);
    end
    tick();
    we = 1'b0;
    #1;
    tests++;
    if (rd_busy[0] !== 1'b0 || rd_data[DW-1:0] !== 64'h77) begin
      fails++;
      $display("FAIL after_write: busy=%b data=%h want 0/77", rd_busy[0], rd_data[DW-1:0]);
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    claim_addr = 5'd9;
    tick();
    flush = 1'b1; claim_addr = 5'd9;
    we = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
    tick();
    idle_inputs();
    a0 = 5'd9; a1 = 5'd3;
    #1;
    tests++;
    if (rd_data[DW-1:0] !== 64'h55 || rd_busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL simul_r9: data=%h busy=%b want 55/1", rd_data[DW-1:0], rd_busy[0]);
    end
    for (int r = 0; r < NR; r++) begin
      if (r != 9) begin
        a1 = AW'(r);
        #1;
        tests++;
        if (rd_busy[1] !== 1'b0) begin
          fails++;
          $display("FAIL simul_flush r%0d: busy=%b want 0", r, rd_busy[1]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    idle_inputs();
    for (int r = 0; r < NR; r++) begin
      we = 1'b1; wr_addr = AW'(r); wr_data = DW'(r);
      tick();
    end
    we = 1'b0;
    a0 = 5'd17; a1 = 5'd9;
    #1;
    tests++;
    if (rd_data[DW-1:0] !== 64'd17) begin
      fails++;
      $display("FAIL fill_r17: got %h want 11", rd_data[DW-1:0]);
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      if (cnt == 10) begin
        we = 1'b1; wr_addr = 5'd3; wr_data = 64'hABC;
        a0 = 5'd3;
        #1;
        tests++;
        if (rd_data[DW-1:0] !== '0 || rd_busy[0] !== 1'b0) begin
          fails++;
          $display("FAIL clear_no_bypass: data=%h busy=%b want 0/0", rd_data[DW-1:0], rd_busy[0]);
        end
      end
      if (cnt == 15) clr_start = 1'b1;
      tick();
      we = 1'b0; clr_start = 1'b0;
      cnt++;
    end
    tests++;
    if (cnt != NR) begin
      fails++;
      $display("FAIL clear_duration: busy for %0d cycles, want %0d", cnt, NR);
    end
    for (int r = 0; r < NR; r++) begin
      a0 = AW'(r);
      #1;
      tests++;
      if (rd_data[DW-1:0] !== '0) begin
        fails++;
        $display("FAIL clear_result r%0d: got %h want 0", r, rd_data[DW-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    for (int r = 0; r < NR; r++) begin
      we = 1'b1; wr_addr = AW'(r); wr_data = DW'(r + 100);
      tick();
    end
    we = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    a0 = 5'd20; a1 = 5'd25;
    #1;
    tests++;
    if (rd_data[DW-1:0] !== 64'd120 || clr_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_state: data=%h busy=%b want 78/1", rd_data[DW-1:0], clr_busy);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (clr_busy !== 1'b0 || rd_data !== '0) begin
      fails++;
      $display("FAIL async_reset: clr_busy=%b rd_data=%h want 0/0", clr_busy, rd_data);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int r = 0; r < NR; r++) begin
      a0 = AW'(r);
      #1;
      tests++;
      if (rd_data[DW-1:0] !== '0 || clr_busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset r%0d: data=%h busy=%b want 0/0", r, rd_data[DW-1:0], clr_busy);
      end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      a0 = AW'($urandom_range(0, 7));
      a1 = AW'($urandom_range(0, NR - 1));
      we = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = {$urandom(), $urandom()};
      claim_en = ($urandom_range(0, 2) == 0);
      claim_addr = AW'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      clr_start = ($urandom_range(0, 99) == 0);
      #1;
      tests++;
      if (clr_busy !== (m_left > 0)) begin
        fails++;
        $display("FAIL rnd_clr_busy c%0d: got %b want %b", c, clr_busy, (m_left > 0));
      end
      tests++;
      if (rd_data[DW-1:0] !== exp_rd(a0) || rd_busy[0] !== exp_busy(a0)) begin
        fails++;
        $display("FAIL rnd_port0 c%0d a=%0d: data=%h busy=%b want %h/%b",
                 c, a0, rd_data[DW-1:0], rd_busy[0], exp_rd(a0), exp_busy(a0));
      end
      tests++;
      if (rd_data[2*DW-1:DW] !== exp_rd(a1) || rd_busy[1] !== exp_busy(a1)) begin
        fails++;
        $display("FAIL rnd_port1 c%0d a=%0d: data=%h busy=%b want %h/%b",
                 c, a1, rd_data[2*DW-1:DW], rd_busy[1], exp_rd(a1), exp_busy(a1));
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    a0 = '0; a1 = '0;
    test_reset();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
